shift_multiplier: RTL and testbench



---
 rtl/shift_multiplier_pkg.sv | 11 +
 rtl/shift_multiplier.sv | 75 +++++++
 tb/tb_shift_multiplier.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/shift_multiplier_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package shift_mul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_multiplier.sv
// Unsigned shift-and-add multiplier: one multiplier bit per clock, fixed WIDTH-clock latency,
// registered product with a single-cycle done pulse.
module shift_multiplier
  import shift_mul_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc_next;

  // The partial product can never exceed 2*WIDTH bits, so the add needs no carry-out.
  always_comb begin
    acc_next = acc;
    if (mplier_r[0]) acc_next = acc + mcand_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      acc      <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, multiplicand};
            mplier_r <= multiplier;
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc      <= acc_next;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt      <= cnt + 1'b1;
          // The last iteration's add is folded straight into the published product.
          if (cnt == LAST_CNT) begin
            product <= acc_next;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_multiplier.sv
// Self-checking bench for shift_multiplier: directed table, multi-cycle corner sequences,
// a WIDTH=4 instance and a randomized sweep against plain A*B.
module tb_shift_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  logic        start4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  product4;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .multiplicand(a), .multiplier(b),
    .busy(busy), .done(done), .product(product)
  );

  shift_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .multiplicand(a4), .multiplier(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request to the WIDTH=8 instance and wait (bounded) for done.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                       output logic [15:0] p, output int lat, output int bcyc);
    a = x; b = y; start = 1'b1;
    step(1);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    lat = 0; bcyc = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      step(1);
      lat++;
    end
    p = product;
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      step(1);
      if (done) cnt++;
    end
  endtask

  initial begin
    logic [15:0] p, exp;
    logic [7:0]  x, y;
    int lat, bcyc, nd, t_first, t_second;

    vecs[0] = '{8'hAA, 8'h08, 16'h0550};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'h5A, 16'h0000};
    vecs[3] = '{8'h01, 8'h01, 16'h0001};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    step(2);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_product", 32'(product), 0);
    check("reset_product_w4", 32'(product4), 0);

    // rst outranks a simultaneous start.
    start = 1'b1; a = 8'h33; b = 8'h44;
    step(1);
    check("rst_beats_start_busy", 32'(busy), 0);
    rst = 1'b0; start = 1'b0;
    step(1);

    for (int i = 0; i < 4; i++) begin
      do_op(vecs[i].a, vecs[i].b, p, lat, bcyc);
      check($sformatf("vec%0d_product", i), 32'(p), 32'(vecs[i].p));
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_busy_cycles", i), bcyc, 8);
      step(1);
      check($sformatf("vec%0d_done_width", i), 32'(done), 0);
      check($sformatf("vec%0d_product_hold", i), 32'(product), 32'(vecs[i].p));
    end

    // A second start while busy must be dropped.
    a = 8'h03; b = 8'h05; start = 1'b1;
    step(1);
    start = 1'b0; a = 8'h00; b = 8'h00;
    step(2);
    a = 8'h7F; b = 8'h7F; start = 1'b1;
    step(1);
    start = 1'b0;
    nd = 0; lat = 3;
    while (!done && lat < 40) begin step(1); lat++; end
    check("busy_start_latency", lat, 8);
    check("busy_start_product", 32'(product), 32'h000F);
    count_dones(12, nd);
    check("busy_start_extra_dones", nd, 0);
    check("busy_start_product_hold", 32'(product), 32'h000F);

    // Back-to-back: second start presented in the done cycle of the first.
    do_op(8'h02, 8'h03, p, lat, bcyc);
    t_first = cyc;
    check("b2b_first_product", 32'(p), 32'h0006);
    do_op(8'h10, 8'h10, p, lat, bcyc);
    t_second = cyc;
    check("b2b_second_product", 32'(p), 32'h0100);
    check("b2b_done_spacing", t_second - t_first, 9);
    step(1);

    // Reset mid-operation aborts without a done pulse.
    a = 8'hC3; b = 8'h3C; start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("abort_done", 32'(done), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_product", 32'(product), 0);
    count_dones(12, nd);
    check("abort_no_done", nd, 0);
    do_op(8'h0C, 8'h0A, p, lat, bcyc);
    check("after_abort_product", 32'(p), 32'h0078);
    check("after_abort_latency", lat, 8);
    step(1);

    // WIDTH=4 instance.
    a4 = 4'hF; b4 = 4'hD; start4 = 1'b1;
    step(1);
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    lat = 0;
    while (!done4 && lat < 40) begin step(1); lat++; end
    check("w4_latency", lat, 4);
    check("w4_product", 32'(product4), 32'h00C3);
    step(1);
    check("w4_done_width", 32'(done4), 0);

    // Randomized sweep against the arithmetic definition of the product.
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      exp = 16'(x) * 16'(y);
      do_op(x, y, p, lat, bcyc);
      check($sformatf("rand%0d_%02h_x_%02h", i, x, y), 32'(p), 32'(exp));
      check($sformatf("rand%0d_latency", i), lat, 8);
      if (($urandom & 1) != 0) step(1 + int'($urandom_range(2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
